// File: rtl/mfcc_mel_filter_acc.sv
// Mel-filter energy accumulator: weights each streamed power bin by its mel-bank ROM coefficient and sums over a frame.
// Optional saturating accumulation is enabled by defining MEL_ACC_SAT_EN; otherwise the accumulator wraps.
module mfcc_mel_filter_acc #(
    parameter int ADDR_WIDTH = 9,
    parameter int COEF_WIDTH = 8,
    parameter int PWR_WIDTH  = 32,
    parameter int ACC_WIDTH  = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [PWR_WIDTH-1:0]  s_data,
    input  logic                  s_last,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [COEF_WIDTH-1:0] rom_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ACC_WIDTH-1:0]  m_data,
    output logic                  m_sat
);

    localparam int PROD_WIDTH = PWR_WIDTH + COEF_WIDTH;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   bin_cnt;
    logic [PROD_WIDTH-1:0]   prod;
    logic                    pv;
    logic [ACC_WIDTH-1:0]    acc;
    logic                    sat;
    logic                    ready_q;
    logic                    valid_q;

    logic                    accept;
    logic                    frame_close;
    logic [ACC_WIDTH-1:0]    acc_next;
    logic                    sat_next;

    assign accept      = s_valid & ready_q;
    assign frame_close = accept & (s_last | (bin_cnt == {ADDR_WIDTH{1'b1}}));

`ifdef MEL_ACC_SAT_EN
    logic [ACC_WIDTH:0] sum_wide;

    // Saturating add: once the frame overflows, the accumulator stays pinned at all-ones.
    always_comb begin
        sum_wide = {1'b0, acc} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, prod};
        if (sat || sum_wide[ACC_WIDTH]) begin
            acc_next = {ACC_WIDTH{1'b1}};
            sat_next = 1'b1;
        end else begin
            acc_next = sum_wide[ACC_WIDTH-1:0];
            sat_next = sat;
        end
    end
`else
    // Wrapping add modulo 2^ACC_WIDTH.
    always_comb begin
        acc_next = acc + {{(ACC_WIDTH - PROD_WIDTH){1'b0}}, prod};
        sat_next = 1'b0;
    end
`endif

    // Multiply stage, accumulate stage and frame-control FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_ACC;
            bin_cnt <= {ADDR_WIDTH{1'b0}};
            prod    <= {PROD_WIDTH{1'b0}};
            pv      <= 1'b0;
            acc     <= {ACC_WIDTH{1'b0}};
            sat     <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pv <= accept;
            if (accept) begin
                prod <= PROD_WIDTH'(s_data) * PROD_WIDTH'(rom_data);
            end
            if (pv) begin
                acc <= acc_next;
                sat <= sat_next;
            end
            case (state)
                ST_ACC: begin
                    // First cycle out of reset raises s_ready; bins arrive from then on.
                    ready_q <= ~frame_close;
                    if (accept) begin
                        bin_cnt <= frame_close ? {ADDR_WIDTH{1'b0}} : bin_cnt + ADDR_WIDTH'(1);
                    end
                    if (frame_close) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (m_ready) begin
                        valid_q <= 1'b0;
                        acc     <= {ACC_WIDTH{1'b0}};
                        sat     <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= ST_ACC;
                    end
                end
                default: begin
                    state   <= ST_ACC;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready  = ready_q;
    assign rom_addr = bin_cnt;
    assign m_valid  = valid_q;
    assign m_data   = acc;
    assign m_sat    = sat;

endmodule

// File: tb/tb_mfcc_mel_filter_acc.sv
// Self-checking bench for mfcc_mel_filter_acc: directed frames plus randomized data/bubbles checked against a sum-of-products model.
module tb_mfcc_mel_filter_acc;

    localparam int AW = 9;
    localparam int CW = 8;
    localparam int PW = 32;
    localparam int W  = 48;
    localparam int NB = 1 << AW;
    localparam logic [63:0] MAXV = (64'd1 << W) - 64'd1;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] s_data;
    logic          s_last;
    logic [AW-1:0] rom_addr;
    logic [CW-1:0] rom_data;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_sat;

    logic [CW-1:0] wts [0:NB-1];
    assign rom_data = wts[rom_addr];

    int n_checks = 0;
    int n_fails  = 0;
    logic [63:0] model_sum;

    always #5 clk = ~clk;

    mfcc_mel_filter_acc #(
        .ADDR_WIDTH(AW), .COEF_WIDTH(CW), .PWR_WIDTH(PW), .ACC_WIDTH(W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_energy(input logic [63:0] s);
`ifdef MEL_ACC_SAT_EN
        return (s > MAXV) ? MAXV : s;
`else
        return s & MAXV;
`endif
    endfunction

    function automatic logic [63:0] exp_sat(input logic [63:0] s);
`ifdef MEL_ACC_SAT_EN
        return (s > MAXV) ? 64'd1 : 64'd0;
`else
        return 64'd0 + (s & 64'd0);
`endif
    endfunction

    task automatic set_weights(input int mode);
        for (int i = 0; i < NB; i++) begin
            case (mode)
                0:       wts[i] = 8'h80;
                1:       wts[i] = 8'h01;
                2:       wts[i] = 8'hFF;
                default: wts[i] = 8'($urandom_range(255));
            endcase
        end
    endtask

    // Streams nbins accepted bins; the model sum is the plain sum of data*weight over accepted bins.
    task automatic feed(input int nbins, input bit last_at_end, input int mode, input int bubble_pct);
        int idx = 0;
        int guard = 0;
        logic [PW-1:0] d;
        model_sum = 64'd0;
        while (idx < nbins && guard < 20000) begin
            @(negedge clk);
            guard++;
            chk("rom_addr_track", 64'(rom_addr), 64'(idx % NB));
            case (mode)
                0:       d = 32'd1;
                1:       d = 32'(idx);
                2:       d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
            s_valid = ($urandom_range(99) >= bubble_pct) ? 1'b1 : 1'b0;
            s_data  = d;
            s_last  = (last_at_end && idx == nbins - 1) ? 1'b1 : 1'b0;
            if (s_valid && s_ready) begin
                model_sum = model_sum + 64'(d) * 64'(wts[idx]);
                idx++;
            end
        end
        if (guard >= 20000) chk("feed_budget", 64'd0, 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 32'd0;
    endtask

    // Checks close latency, holds m_ready low for hold cycles, then completes the handshake.
    task automatic collect(input string tag, input int hold);
        logic [63:0] exp;
        exp = exp_energy(model_sum);
        chk({tag, "_mvalid_e0"}, 64'(m_valid), 64'd0);
        chk({tag, "_sready_e0"}, 64'(s_ready), 64'd0);
        @(negedge clk);
        chk({tag, "_mvalid_e1"}, 64'(m_valid), 64'd0);
        chk({tag, "_romaddr_close"}, 64'(rom_addr), 64'd0);
        @(negedge clk);
        chk({tag, "_mvalid_e2"}, 64'(m_valid), 64'd1);
        chk({tag, "_mdata"}, 64'(m_data), exp);
        chk({tag, "_msat"}, 64'(m_sat), exp_sat(model_sum));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_mdata"}, 64'(m_data), exp);
            chk({tag, "_hold_mvalid"}, 64'(m_valid), 64'd1);
            chk({tag, "_hold_sready"}, 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk({tag, "_post_mvalid"}, 64'(m_valid), 64'd0);
        chk({tag, "_post_sready"}, 64'(s_ready), 64'd1);
        chk({tag, "_post_romaddr"}, 64'(rom_addr), 64'd0);
        chk({tag, "_post_mdata"}, 64'(m_data), 64'd0);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0; m_ready = 1'b0;
        set_weights(0);
        repeat (3) @(negedge clk);
        chk("rst_sready", 64'(s_ready), 64'd0);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_mdata", 64'(m_data), 64'd0);
        chk("rst_msat", 64'(m_sat), 64'd0);
        chk("rst_romaddr", 64'(rom_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sready", 64'(s_ready), 64'd1);

        // Weights 0x80, unit data, explicit last on bin 511.
        feed(NB, 1'b1, 0, 0);
        chk("s1_model", model_sum, 64'd65536);
        collect("s1", 0);

        // Weights 1, data = bin index, early last at bin 9.
        set_weights(1);
        feed(10, 1'b1, 1, 0);
        chk("s2_model", model_sum, 64'd45);
        collect("s2", 0);

        // No s_last: implicit close at bin 511, consumer stalls 10 cycles.
        set_weights(0);
        feed(NB, 1'b0, 0, 0);
        collect("s3", 10);

        // Random bubbles, same data as the first frame.
        feed(NB, 1'b1, 0, 40);
        chk("s4_model", model_sum, 64'd65536);
        collect("s4", 2);

        // Full-scale data and weights: wraps or saturates depending on build.
        set_weights(2);
        feed(NB, 1'b0, 2, 0);
        chk("s5_model", exp_energy(model_sum),
`ifdef MEL_ACC_SAT_EN
            64'hFFFF_FFFF_FFFF);
`else
            64'hFDFF_FFFE_0200);
`endif
        collect("s5", 1);

        // Reset mid-frame after 200 bins, then a clean first-scenario frame.
        set_weights(0);
        feed(200, 1'b0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_mvalid", 64'(m_valid), 64'd0);
        chk("s6_rst_romaddr", 64'(rom_addr), 64'd0);
        chk("s6_rst_sready", 64'(s_ready), 64'd0);
        chk("s6_rst_mdata", 64'(m_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("s6_sready", 64'(s_ready), 64'd1);
        feed(NB, 1'b1, 0, 0);
        collect("s6", 0);

        // Random weights, random data, random frame length and bubbles.
        for (int f = 0; f < 4; f++) begin
            set_weights(3);
            feed(int'($urandom_range(NB, 1)), 1'b1, 3, 25);
            collect("rnd", int'($urandom_range(3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
